// File: rtl/inc_dec_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : inc_dec_pulse_sequencer
// Purpose  : Emits a commanded number of inc/dec pulses with a programmable gap.
// Revision : 1.0 - initial release
// ============================================================================
module inc_dec_pulse_sequencer #(
  parameter int CNT_W = 5,
  parameter int GAP_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [CNT_W-1:0] i_num,
  input  logic [GAP_W-1:0] i_gap,
  input  logic             i_abort,
  output logic             o_inc,
  output logic             o_dec,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_remaining
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_PULSE = 2'd1;
  localparam logic [1:0] c_GAP   = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [1:0] c_OP_INC  = 2'b00;
  localparam logic [1:0] c_OP_DEC  = 2'b01;
  localparam logic [1:0] c_OP_BOTH = 2'b10;
  localparam logic [1:0] c_OP_NOP  = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       r_op;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gcnt;
  logic [CNT_W-1:0] r_rem;
  logic             r_abt;

  logic             w_accept;
  logic             w_last;
  logic             w_inc;
  logic             w_dec;
  logic             w_busy;
  logic             w_done;
  logic             w_aborted;

  assign w_accept = i_start && (i_num != '0) && (i_op != c_OP_NOP);
  assign w_last   = (r_rem == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (i_start) begin
          w_state_nxt = w_accept ? c_PULSE : c_DONE;
        end
      end
      c_PULSE: begin
        if (w_last || i_abort) begin
          w_state_nxt = c_DONE;
        end else if (r_gap == '0) begin
          w_state_nxt = c_PULSE;
        end else begin
          w_state_nxt = c_GAP;
        end
      end
      c_GAP: begin
        if (i_abort) begin
          w_state_nxt = c_DONE;
        end else if (r_gcnt == GAP_W'(1)) begin
          w_state_nxt = c_PULSE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // Command latch, pulse and gap counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= c_OP_INC;
      r_gap  <= '0;
      r_gcnt <= '0;
      r_rem  <= '0;
      r_abt  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_abt <= 1'b0;
          if (w_accept) begin
            r_op  <= i_op;
            r_gap <= i_gap;
            r_rem <= i_num;
          end
        end
        c_PULSE: begin
          r_rem  <= r_rem - CNT_W'(1);
          r_gcnt <= r_gap;
          // Abort on the final pulse leaves nothing unissued, so it is not flagged
          if (i_abort && !w_last) begin
            r_abt <= 1'b1;
          end
        end
        c_GAP: begin
          r_gcnt <= r_gcnt - GAP_W'(1);
          if (i_abort) begin
            r_abt <= 1'b1;
          end
        end
        default: begin
          r_rem <= '0;
          r_abt <= 1'b0;
        end
      endcase
    end
  end

  // Output decode from the current state
  always_comb begin
    w_inc     = 1'b0;
    w_dec     = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_aborted = 1'b0;
    case (r_state)
      c_PULSE: begin
        w_inc  = (r_op == c_OP_INC) || (r_op == c_OP_BOTH);
        w_dec  = (r_op == c_OP_DEC) || (r_op == c_OP_BOTH);
        w_busy = 1'b1;
      end
      c_GAP: begin
        w_busy = 1'b1;
      end
      c_DONE: begin
        w_done    = 1'b1;
        w_aborted = r_abt;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Registered outputs trail the state register by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      o_inc       <= 1'b0;
      o_dec       <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_aborted   <= 1'b0;
      o_remaining <= '0;
    end else begin
      o_inc       <= w_inc;
      o_dec       <= w_dec;
      o_busy      <= w_busy;
      o_done      <= w_done;
      o_aborted   <= w_aborted;
      o_remaining <= r_rem;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inc_dec_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_inc_dec_pulse_sequencer
// Purpose  : Directed self-checking bench for inc_dec_pulse_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inc_dec_pulse_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [1:0] i_op = 2'b00;
  logic [4:0] i_num = 5'd0;
  logic [1:0] i_gap = 2'd0;
  logic       i_abort = 1'b0;
  logic       o_inc, o_dec, o_busy, o_done, o_aborted;
  logic [4:0] o_remaining;

  int n_tests = 0;
  int n_fail  = 0;

  int m_first, m_last, m_inc, m_dec, m_both, m_busy, m_done_k, m_rem, m_abt;
  int m_cnt = 0;

  inc_dec_pulse_sequencer #(.CNT_W(5), .GAP_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_num       (i_num),
    .i_gap       (i_gap),
    .i_abort     (i_abort),
    .o_inc       (o_inc),
    .o_dec       (o_dec),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_aborted   (o_aborted),
    .o_remaining (o_remaining)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_inc"},  int'(o_inc), 0);
    chk({tag, "_dec"},  int'(o_dec), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_abt"},  int'(o_aborted), 0);
    chk({tag, "_rem"},  int'(o_remaining), 0);
  endtask

  // Start strobe is sampled at edge T; on return we sit in cycle T
  task automatic issue(input logic [1:0] op, input int num, input int gap);
    i_op    = op;
    i_num   = 5'(num);
    i_gap   = 2'(gap);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("busy_in_cycle_T", int'(o_busy), 0);
  endtask

  // Observes cycles T+k until done or budget; k of each event is recorded
  task automatic run(input int abort_at, input int rst_at, input int restart_at, input int budget);
    m_first = -1; m_last = -1; m_inc = 0; m_dec = 0; m_both = 0;
    m_busy = 0; m_done_k = -1; m_rem = -1; m_abt = -1;
    for (int k = 1; k <= budget; k++) begin
      tick;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk_idle("mid_reset");
        rst = 1'b0;
      end
      if (o_inc || o_dec) begin
        if (m_first < 0) m_first = k;
        m_last = k;
      end
      m_inc  += int'(o_inc);
      m_dec  += int'(o_dec);
      m_both += int'(o_inc & o_dec);
      m_busy += int'(o_busy);
      if (o_inc && !o_dec)      m_cnt = (m_cnt + 1) % 13;
      else if (o_dec && !o_inc) m_cnt = (m_cnt + 12) % 13;
      i_abort = (k == abort_at);
      i_start = (k == restart_at);
      if (k == restart_at) begin
        i_op  = 2'b01;
        i_num = 5'd3;
      end
      if (k == rst_at) rst = 1'b1;
      if (o_done) begin
        m_done_k = k;
        m_rem    = int'(o_remaining);
        m_abt    = int'(o_aborted);
        break;
      end
    end
    i_abort = 1'b0;
    i_start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick; tick; tick;
    chk_idle("reset");
    rst = 1'b0;
    tick;

    // 10 inc pulses, gap 2
    issue(2'b00, 10, 2);
    run(0, 0, 0, 60);
    chk("t1_first",  m_first, 1);
    chk("t1_inc",    m_inc, 10);
    chk("t1_dec",    m_dec, 0);
    chk("t1_busy",   m_busy, 28);
    chk("t1_span",   m_last - m_first, 27);
    chk("t1_done_k", m_done_k, 29);
    chk("t1_rem",    m_rem, 0);
    chk("t1_abt",    m_abt, 0);

    // 7 back-to-back dec pulses move a mod-13 counter from 0 to 6
    m_cnt = 0;
    issue(2'b01, 7, 0);
    run(0, 0, 0, 60);
    chk("t2_dec",    m_dec, 7);
    chk("t2_inc",    m_inc, 0);
    chk("t2_busy",   m_busy, 7);
    chk("t2_done_k", m_done_k, 8);
    chk("t2_cnt",    m_cnt, 6);

    // Start issued in the done cycle: first pulse two cycles after done
    issue(2'b10, 1, 0);
    run(0, 0, 0, 60);
    chk("t3_first",  m_first, 1);
    chk("t3_both",   m_both, 1);
    chk("t3_inc",    m_inc, 1);
    chk("t3_busy",   m_busy, 1);
    chk("t3_done_k", m_done_k, 2);

    // num = 0 and op = 11 complete immediately with no pulses
    issue(2'b00, 0, 3);
    run(0, 0, 0, 20);
    chk("t4a_done_k", m_done_k, 1);
    chk("t4a_busy",   m_busy, 0);
    chk("t4a_pulses", m_inc + m_dec, 0);
    issue(2'b11, 5, 1);
    run(0, 0, 0, 20);
    chk("t4b_done_k", m_done_k, 1);
    chk("t4b_busy",   m_busy, 0);
    chk("t4b_pulses", m_inc + m_dec, 0);
    chk("t4b_rem",    m_rem, 0);

    // Abort while idle has no effect
    tick;
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    tick;
    chk("idle_abort_done", int'(o_done), 0);
    chk("idle_abort_busy", int'(o_busy), 0);

    // Second start while busy is ignored
    issue(2'b00, 4, 1);
    run(0, 0, 2, 60);
    chk("t5_inc",    m_inc, 4);
    chk("t5_dec",    m_dec, 0);
    chk("t5_busy",   m_busy, 7);
    chk("t5_done_k", m_done_k, 8);
    run(0, 0, 0, 5);
    chk("t5_extra",  m_inc + m_dec + m_busy, 0);

    // Abort sampled during the 3rd GAP state, which runs one cycle ahead
    // of the registered outputs: driven while the 3rd pulse is visible
    issue(2'b00, 8, 1);
    run(5, 0, 0, 60);
    chk("t6_inc",    m_inc, 3);
    chk("t6_busy",   m_busy, 6);
    chk("t6_done_k", m_done_k, 7);
    chk("t6_rem",    m_rem, 5);
    chk("t6_abt",    m_abt, 1);
    tick;
    chk("t6_abt_after", int'(o_aborted), 0);
    chk("t6_rem_after", int'(o_remaining), 0);

    // Reset during the 4th pulse of a 10-pulse command
    issue(2'b00, 10, 1);
    run(0, 7, 0, 30);
    chk("t7_inc",    m_inc, 4);
    chk("t7_done_k", m_done_k, -1);
    issue(2'b00, 2, 0);
    run(0, 0, 0, 20);
    chk("t8_inc",    m_inc, 2);
    chk("t8_first",  m_first, 1);
    chk("t8_done_k", m_done_k, 3);
    chk("t8_abt",    m_abt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
